// File: rtl/hack_dmux4_way16_stream_pkg.sv
// rtl/hack_dmux4_way16_stream_pkg.sv - shared widths and channel-select type for the 1-to-4 stream demux
package hack_dmux_pkg;

  localparam int HACK_WORD_W = 16;
  localparam int HACK_NUM_CH = 4;

  typedef logic [1:0] hack_ch_sel_t;

endpackage

// File: rtl/hack_dmux4_way16_stream_if.sv
// rtl/hack_dmux4_way16_stream_if.sv - bundle of the demux source side and the four channel outputs
import hack_dmux_pkg::*;

interface hack_dmux4_way16_stream_if #(
  parameter int WIDTH = HACK_WORD_W
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  hack_ch_sel_t     sel;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_a, out_b, out_c, out_d, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_a, out_b, out_c, out_d, out_valid
  );
endinterface

// File: rtl/hack_dmux4_way16_stream_slot.sv
// rtl/hack_dmux4_way16_stream_slot.sv - one-entry holding register with load, drain and full flag
import hack_dmux_pkg::*;

module hack_dmux_slot #(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_d, full_q;
  logic [WIDTH-1:0] data_d, data_q;

  // A load on the draining edge wins, so the slot stays full with the new word.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = load_data;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/hack_dmux4_way16_stream.sv
// rtl/hack_dmux4_way16_stream.sv - 1-to-4 stream demux with a holding register per channel
// Optional HACK_DMUX4_AUTO_SEL_EN: round-robin pointer replaces sel as destination.
import hack_dmux_pkg::*;

module hack_dmux4_way16_stream #(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  hack_ch_sel_t     sel,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
);

  hack_ch_sel_t     dest;
  logic             accept;
  logic [3:0]       full;
  logic [3:0]       load;
  logic [3:0]       drain;
  logic [WIDTH-1:0] data [HACK_NUM_CH];

`ifdef HACK_DMUX4_AUTO_SEL_EN
  hack_ch_sel_t ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = ptr_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign dest = ptr_q;
`else
  assign dest = sel;
`endif

  // A full destination can still accept when it drains on the same edge.
  assign in_ready = !full[dest] || out_ready[dest];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load  = '0;
    drain = full & out_ready;
    if (accept) load[dest] = 1'b1;
  end

  for (genvar k = 0; k < HACK_NUM_CH; k++) begin : g_slot
    hack_dmux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .drain     (drain[k]),
      .full      (full[k]),
      .data      (data[k])
    );
  end

  assign out_a     = data[0];
  assign out_b     = data[1];
  assign out_c     = data[2];
  assign out_d     = data[3];
  assign out_valid = full;

endmodule

// File: tb/tb_hack_dmux4_way16_stream.sv
// tb/tb_hack_dmux4_way16_stream.sv - directed self-checking bench for the 1-to-4 stream demux
import hack_dmux_pkg::*;

module tb_hack_dmux4_way16_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  hack_dmux4_way16_stream_if #(.WIDTH(16)) bus ();

  hack_dmux4_way16_stream #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (bus.in_data),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .sel       (bus.sel),
    .out_a     (bus.out_a),
    .out_b     (bus.out_b),
    .out_c     (bus.out_c),
    .out_d     (bus.out_d),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] out_of(input int k);
    case (k)
      0:       return bus.out_a;
      1:       return bus.out_b;
      2:       return bus.out_c;
      default: return bus.out_d;
    endcase
  endfunction

  task automatic send(input logic [1:0] s, input logic [15:0] w);
    bus.sel      = s;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {28'd0, bus.out_valid}, 32'h0);
    check({tag, "_a"}, {16'd0, bus.out_a}, 32'h0);
    check({tag, "_b"}, {16'd0, bus.out_b}, 32'h0);
    check({tag, "_c"}, {16'd0, bus.out_c}, 32'h0);
    check({tag, "_d"}, {16'd0, bus.out_d}, 32'h0);
  endtask

  initial begin
    bus.in_data   = 16'hFFFF;
    bus.in_valid  = 1'b1;
    bus.sel       = 2'd0;
    bus.out_ready = 4'b0000;
    rst_n         = 1'b0;
    step();
    step();
    check_all_zero("rst");
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'h1);

    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    step();
    step();
    check_all_zero("post_rst");
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'h1);

`ifdef HACK_DMUX4_AUTO_SEL_EN
    bus.sel       = 2'd3;
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 16'hA000 + 16'(i);
      step();
      check($sformatf("auto_word%0d", i), {16'd0, out_of(i % 4)}, 32'hA000 + i);
      check($sformatf("auto_valid%0d", i), {28'd0, bus.out_valid}, 32'(1 << (i % 4)));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
`else
    send(2'd0, 16'h1234);
    send(2'd1, 16'h9876);
    send(2'd2, 16'hAAAA);
    send(2'd3, 16'h5555);
    check("route_a", {16'd0, bus.out_a}, 32'h1234);
    check("route_b", {16'd0, bus.out_b}, 32'h9876);
    check("route_c", {16'd0, bus.out_c}, 32'hAAAA);
    check("route_d", {16'd0, bus.out_d}, 32'h5555);
    check("route_valid", {28'd0, bus.out_valid}, 32'hF);

    bus.sel      = 2'd2;
    bus.in_data  = 16'hDEAD;
    step();
    check("sel_only_c", {16'd0, bus.out_c}, 32'hAAAA);

    bus.sel      = 2'd1;
    bus.in_data  = 16'h0BEE;
    bus.in_valid = 1'b1;
    #1;
    check("bp_in_ready", {31'd0, bus.in_ready}, 32'h0);
    step();
    check("bp_hold_b", {16'd0, bus.out_b}, 32'h9876);
    bus.out_ready = 4'b0010;
    #1;
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'h1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    check("bp_new_b", {16'd0, bus.out_b}, 32'h0BEE);
    check("bp_valid", {28'd0, bus.out_valid}, 32'hF);

    bus.out_ready = 4'b0100;
    step();
    bus.out_ready = 4'b0000;
    check("drain_c_valid", {28'd0, bus.out_valid}, 32'hB);

    bus.sel       = 2'd2;
    bus.in_data   = 16'hC0DE;
    bus.in_valid  = 1'b1;
    bus.out_ready = 4'b0001;
    #1;
    check("mix_in_ready", {31'd0, bus.in_ready}, 32'h1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    check("mix_valid", {28'd0, bus.out_valid}, 32'hE);
    check("mix_c", {16'd0, bus.out_c}, 32'hC0DE);
    check("mix_a_kept", {16'd0, bus.out_a}, 32'h1234);

    send(2'd0, 16'h1111);
    check("refill_valid", {28'd0, bus.out_valid}, 32'hF);
`endif

    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {28'd0, bus.out_valid}, 32'h0);
    step();
    rst_n = 1'b1;
    check_all_zero("mid_rst");
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'h1);

`ifdef HACK_DMUX4_AUTO_SEL_EN
    send(2'd3, 16'h7777);
    check("after_rst_a", {16'd0, bus.out_a}, 32'h7777);
    check("after_rst_valid", {28'd0, bus.out_valid}, 32'h1);
`else
    send(2'd3, 16'h7777);
    check("after_rst_d", {16'd0, bus.out_d}, 32'h7777);
    check("after_rst_valid", {28'd0, bus.out_valid}, 32'h8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
